// File: rtl/iis_tx_serializer.sv
// Philips I2S transmitter fed from the 16-bit TX FIFO: prefetches one word and shifts it out MSB first.
// Optional build macro IIS_TX_MONO_EN sends each FIFO word in both the left and the right slot.
`timescale 1ns/1ps
module iis_tx_serializer #(
    parameter int DATA_W  = 16,
    parameter int CLK_DIV = 4
) (
    input  logic              pclk,
    input  logic              presetn,
    input  logic              en_i,
    input  logic              fifo_empty_i,
    input  logic [DATA_W-1:0] fifo_data_i,
    output logic              fifo_rden_o,
    output logic              sck_o,
    output logic              ws_o,
    output logic              sd_o,
    output logic              busy_o,
    output logic              underrun_o,
    output logic [31:0]       sample_cnt_o
);

    localparam int                BIT_W    = $clog2(DATA_W);
    localparam logic [BIT_W-1:0]  LAST_BIT = BIT_W'(DATA_W - 1);
    localparam logic [7:0]        DIV_LAST = 8'(CLK_DIV - 1);

    typedef enum logic {
        ST_IDLE,
        ST_RUN
    } state_t;

    state_t              r_state;
    logic [7:0]          r_div_cnt;
    logic [BIT_W-1:0]    r_bit_cnt;
    logic [DATA_W-1:0]   r_shreg;
    logic [DATA_W-1:0]   r_hold;
    logic                r_hold_valid;
    logic                r_pop_pending;
`ifdef IIS_TX_MONO_EN
    logic [DATA_W-1:0]   r_mono;
`endif

    logic w_tc;
    logic w_fall;
    logic w_slot_end;
    logic w_pop;

    assign w_tc       = (r_state == ST_RUN) && (r_div_cnt == DIV_LAST);
    assign w_fall     = w_tc && sck_o;
    assign w_slot_end = (r_bit_cnt == LAST_BIT);
    // At most one word is ever in flight: a pop is only issued into an empty hold register
    assign w_pop      = en_i && !fifo_empty_i && !r_hold_valid && !fifo_rden_o && !r_pop_pending;

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            r_state       <= ST_IDLE;
            r_div_cnt     <= '0;
            r_bit_cnt     <= '0;
            r_shreg       <= '0;
            r_hold        <= '0;
            r_hold_valid  <= 1'b0;
            r_pop_pending <= 1'b0;
`ifdef IIS_TX_MONO_EN
            r_mono        <= '0;
`endif
            fifo_rden_o   <= 1'b0;
            sck_o         <= 1'b0;
            ws_o          <= 1'b1;
            sd_o          <= 1'b0;
            busy_o        <= 1'b0;
            underrun_o    <= 1'b0;
            sample_cnt_o  <= '0;
        end else begin
            fifo_rden_o   <= w_pop;
            r_pop_pending <= fifo_rden_o;
            underrun_o    <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    sck_o     <= 1'b0;
                    ws_o      <= 1'b1;
                    sd_o      <= 1'b0;
                    r_div_cnt <= '0;
                    busy_o    <= 1'b0;
                    if (en_i && r_hold_valid) begin
                        r_bit_cnt <= LAST_BIT;
                        r_shreg   <= '0;
                        r_state   <= ST_RUN;
                        busy_o    <= 1'b1;
                    end
                end

                ST_RUN: begin
                    if (w_tc) begin
                        sck_o     <= ~sck_o;
                        r_div_cnt <= '0;
                    end else begin
                        r_div_cnt <= r_div_cnt + 8'd1;
                    end

                    if (w_fall) begin
                        sd_o <= r_shreg[DATA_W-1];
                        if (w_slot_end) begin
                            // Stopping only at the end of a right slot keeps stereo frames whole
                            if (ws_o && !en_i) begin
                                sd_o    <= 1'b0;
                                busy_o  <= 1'b0;
                                r_state <= ST_IDLE;
                            end else begin
                                ws_o      <= ~ws_o;
                                r_bit_cnt <= '0;
`ifdef IIS_TX_MONO_EN
                                if (!ws_o) begin
                                    r_shreg <= r_mono;
                                end else if (r_hold_valid) begin
                                    r_shreg      <= r_hold;
                                    r_mono       <= r_hold;
                                    r_hold_valid <= 1'b0;
                                    sample_cnt_o <= sample_cnt_o + 32'd1;
                                end else begin
                                    r_shreg    <= '0;
                                    r_mono     <= '0;
                                    underrun_o <= 1'b1;
                                end
`else
                                if (r_hold_valid) begin
                                    r_shreg      <= r_hold;
                                    r_hold_valid <= 1'b0;
                                    sample_cnt_o <= sample_cnt_o + 32'd1;
                                end else begin
                                    r_shreg    <= '0;
                                    underrun_o <= 1'b1;
                                end
`endif
                            end
                        end else begin
                            r_shreg   <= r_shreg << 1;
                            r_bit_cnt <= r_bit_cnt + BIT_W'(1);
                        end
                    end
                end

                default: r_state <= ST_IDLE;
            endcase

            // A capture coinciding with a slot load lands after it, so that slot underruns
            if (r_pop_pending) begin
                r_hold       <= fifo_data_i;
                r_hold_valid <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_iis_tx_serializer.sv
// Self-checking bench for iis_tx_serializer: FIFO model plus a bit-level scoreboard checked on every sck fall.
// Build with IIS_TX_MONO_EN defined to exercise the mono variant.
`timescale 1ns/1ps
module tb_iis_tx_serializer;

    localparam int DATA_W  = 16;
    localparam int CLK_DIV = 2;

    logic              pclk         = 1'b0;
    logic              presetn      = 1'b0;
    logic              en_i         = 1'b0;
    logic              fifo_empty_i = 1'b1;
    logic [DATA_W-1:0] fifo_data_i  = '0;
    logic              fifo_rden_o;
    logic              sck_o;
    logic              ws_o;
    logic              sd_o;
    logic              busy_o;
    logic              underrun_o;
    logic [31:0]       sample_cnt_o;

    int testsRun     = 0;
    int testsFailed  = 0;
    int rdenCount    = 0;
    int underrunCount = 0;
    int popFromEmpty = 0;
    int fallIdx      = 0;
    int lastGap      = 0;
    int rdenBase;
    int underrunBase;

    logic [DATA_W-1:0] fifoQ[$];
    bit                expQ[$];

    always #5 pclk = ~pclk;

    iis_tx_serializer #(.DATA_W(DATA_W), .CLK_DIV(CLK_DIV)) dut (
        .pclk        (pclk),
        .presetn     (presetn),
        .en_i        (en_i),
        .fifo_empty_i(fifo_empty_i),
        .fifo_data_i (fifo_data_i),
        .fifo_rden_o (fifo_rden_o),
        .sck_o       (sck_o),
        .ws_o        (ws_o),
        .sd_o        (sd_o),
        .busy_o      (busy_o),
        .underrun_o  (underrun_o),
        .sample_cnt_o(sample_cnt_o)
    );

    // FIFO model: registered read, data valid for the one cycle after the pop, garbage otherwise
    always @(posedge pclk) begin
        if (fifo_rden_o) begin
            if (fifoQ.size() > 0) fifo_data_i <= fifoQ.pop_front();
            else popFromEmpty++;
        end else begin
            fifo_data_i <= DATA_W'($urandom);
        end
        fifo_empty_i <= (fifoQ.size() == 0);
    end

    always @(negedge pclk) begin
        if (fifo_rden_o) rdenCount++;
        if (underrun_o)  underrunCount++;
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        testsRun++;
        if (got !== exp) begin
            testsFailed++;
            $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic [DATA_W-1:0] word, input int copies);
        fifoQ.push_back(word);
        for (int c = 0; c < copies; c++)
            for (int b = DATA_W - 1; b >= 0; b--) expQ.push_back(word[b]);
    endtask

    task automatic pushZeros(input int n);
        for (int i = 0; i < n; i++) expQ.push_back(1'b0);
    endtask

    task automatic applyReset();
        presetn = 1'b0;
        en_i    = 1'b0;
        fifoQ.delete();
        expQ.delete();
        repeat (3) @(negedge pclk);
        presetn = 1'b1;
        @(negedge pclk);
        fallIdx = 0;
        expQ.push_back(1'b0);
    endtask

    task automatic waitFall(output bit found);
        logic lastSck;
        int   cycles;
        found   = 1'b0;
        cycles  = 0;
        lastSck = sck_o;
        while (!found && cycles < 200) begin
            @(negedge pclk);
            cycles++;
            if (lastSck === 1'b1 && sck_o === 1'b0) found = 1'b1;
            lastSck = sck_o;
        end
        lastGap = cycles;
        checkOutput("fallSeen", {31'd0, found}, 32'd1);
    endtask

    task automatic runFalls(input int n);
        for (int i = 0; i < n; i++) begin
            bit f;
            bit e;
            waitFall(f);
            if (!f) return;
            e = (expQ.size() > 0) ? expQ.pop_front() : 1'b0;
            checkOutput($sformatf("sd[%0d]", fallIdx), {31'd0, sd_o}, {31'd0, e});
            checkOutput($sformatf("ws[%0d]", fallIdx), {31'd0, ws_o}, 32'((fallIdx / DATA_W) % 2));
            fallIdx++;
        end
    endtask

    task automatic checkResetOutputs(input string tag);
        checkOutput({tag, ".sck"},      {31'd0, sck_o},       32'd0);
        checkOutput({tag, ".ws"},       {31'd0, ws_o},        32'd1);
        checkOutput({tag, ".sd"},       {31'd0, sd_o},        32'd0);
        checkOutput({tag, ".busy"},     {31'd0, busy_o},      32'd0);
        checkOutput({tag, ".underrun"}, {31'd0, underrun_o},  32'd0);
        checkOutput({tag, ".rden"},     {31'd0, fifo_rden_o}, 32'd0);
        checkOutput({tag, ".count"},    sample_cnt_o,         32'd0);
    endtask

    initial begin
        bit f;

        repeat (3) @(negedge pclk);
        checkResetOutputs("reset");
        presetn = 1'b1;
        @(negedge pclk);
        expQ.push_back(1'b0);
        applyStimulus(16'hA5C3, 1);
        applyStimulus(16'h0F0F, 1);
        rdenBase = rdenCount;
        repeat (20) @(negedge pclk);
        checkOutput("idleNoPop", rdenCount - rdenBase, 0);
        checkOutput("idleBusy", {31'd0, busy_o}, 32'd0);

`ifndef IIS_TX_MONO_EN
        // Two stereo words, then the following slot underruns
        rdenBase = rdenCount; underrunBase = underrunCount;
        fallIdx = 0;
        en_i = 1'b1;
        runFalls(33);
        checkOutput("sckPeriod", lastGap, 2 * CLK_DIV);
        @(negedge pclk);
        checkOutput("t2.count", sample_cnt_o, 32'd2);
        checkOutput("t2.pops", rdenCount - rdenBase, 2);
        checkOutput("t2.underruns", underrunCount - underrunBase, 1);

        // Single word: every following slot is zero-filled with one underrun pulse each
        applyReset();
        applyStimulus(16'h1234, 1);
        pushZeros(2 * DATA_W);
        rdenBase = rdenCount; underrunBase = underrunCount;
        en_i = 1'b1;
        runFalls(1 + 3 * DATA_W);
        @(negedge pclk);
        checkOutput("t3.count", sample_cnt_o, 32'd1);
        checkOutput("t3.pops", rdenCount - rdenBase, 1);
        checkOutput("t3.underruns", underrunCount - underrunBase, 3);

        // Disable mid-left-slot: frame completes, stop replaces the next left load
        applyReset();
        for (int i = 0; i < 6; i++) applyStimulus(16'hFFFF, 1);
        rdenBase = rdenCount; underrunBase = underrunCount;
        en_i = 1'b1;
        runFalls(6);
        en_i = 1'b0;
        runFalls(2 * DATA_W - 6);
        waitFall(f);
        checkOutput("t4.stopSd", {31'd0, sd_o}, 32'd0);
        checkOutput("t4.stopWs", {31'd0, ws_o}, 32'd1);
        repeat (2) @(negedge pclk);
        checkOutput("t4.busy", {31'd0, busy_o}, 32'd0);
        repeat (40) @(negedge pclk);
        checkOutput("t4.sck", {31'd0, sck_o}, 32'd0);
        checkOutput("t4.ws", {31'd0, ws_o}, 32'd1);
        checkOutput("t4.count", sample_cnt_o, 32'd2);
        checkOutput("t4.pops", rdenCount - rdenBase, 2);
        checkOutput("t4.fifoLeft", fifoQ.size(), 4);
        checkOutput("t4.underruns", underrunCount - underrunBase, 0);

        // Asynchronous reset mid-right-slot, then a clean restart
        applyReset();
        applyStimulus(16'hA5C3, 1);
        applyStimulus(16'h0F0F, 1);
        applyStimulus(16'h1111, 1);
        en_i = 1'b1;
        runFalls(20);
        @(negedge pclk);
        presetn = 1'b0;
        #1;
        checkResetOutputs("t5.midReset");
        applyReset();
        applyStimulus(16'hBEEF, 1);
        en_i = 1'b1;
        runFalls(1 + DATA_W);
        @(negedge pclk);
        checkOutput("t5.count", sample_cnt_o, 32'd1);
`else
        // Mono: one word fills both slots; the next left slot underruns
        applyReset();
        applyStimulus(16'h8001, 2);
        rdenBase = rdenCount; underrunBase = underrunCount;
        en_i = 1'b1;
        runFalls(1 + 2 * DATA_W);
        @(negedge pclk);
        checkOutput("t6.count", sample_cnt_o, 32'd1);
        checkOutput("t6.pops", rdenCount - rdenBase, 1);
        checkOutput("t6.underruns", underrunCount - underrunBase, 1);
`endif

        checkOutput("noPopWhenEmpty", popFromEmpty, 0);
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
